// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for a cascaded BCD counter, with
// leading-zero blanking and a frame-stretched event indicator.
module bcd_display_scanner #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned EVT_FRAMES   = 8,
   parameter int unsigned COMMON_ANODE = 1
) (
   input  logic                    clk,
   input  logic                    a_clr,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    hold,
   input  logic                    lzb_en,
   input  logic                    evt_pulse,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    evt_led,
   output logic                    frame_tick
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned EW = $clog2(EVT_FRAMES + 1);
   localparam logic        INV = (COMMON_ANODE != 0);

   logic [PW-1:0]           pre_q;
   logic [IW-1:0]           idx_q;
   logic [4*NUM_DIGITS-1:0] snap_q;
   logic [NUM_DIGITS-1:0]   dpm_q;
   logic [EW-1:0]           evt_cnt_q;
   logic                    frame_tick_q;
   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;

   logic                    slot_tick;
   logic                    idx_last;
   logic [3:0]              cur;
   logic                    cur_dp;
   logic                    blank;
   logic                    run_zero;
   logic [NUM_DIGITS-1:0]   an_d;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   assign slot_tick = (pre_q == PW'(SCAN_DIV - 1));
   assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));

   // Walk from the top digit down; a digit blanks only while every digit above it is zero.
   always_comb begin
      cur      = 4'd0;
      cur_dp   = 1'b0;
      blank    = 1'b0;
      run_zero = 1'b1;
      an_d     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero = run_zero & (snap_q[4*i +: 4] == 4'd0);
         if (IW'(i) == idx_q) begin
            cur     = snap_q[4*i +: 4];
            cur_dp  = dpm_q[i];
            an_d[i] = 1'b1;
            blank   = lzb_en && (i != 0) && run_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge a_clr) begin
      if (!a_clr) begin
         pre_q        <= '0;
         idx_q        <= '0;
         snap_q       <= '0;
         dpm_q        <= '0;
         evt_cnt_q    <= '0;
         frame_tick_q <= 1'b0;
         seg_q        <= '0;
         dp_q         <= 1'b0;
         an_q         <= '0;
      end else begin
         pre_q <= slot_tick ? '0 : pre_q + PW'(1);
         if (slot_tick) begin
            idx_q <= idx_last ? '0 : idx_q + IW'(1);
         end
         frame_tick_q <= slot_tick && idx_last;
         if (!hold) begin
            snap_q <= digits;
            dpm_q  <= dp_mask;
         end
         if (evt_pulse) begin
            evt_cnt_q <= EW'(EVT_FRAMES);
         end else if (frame_tick_q && (evt_cnt_q != '0)) begin
            evt_cnt_q <= evt_cnt_q - EW'(1);
         end
         seg_q <= blank ? 7'h00 : decode(cur);
         dp_q  <= cur_dp;
         an_q  <= an_d;
      end
   end

   // Registers hold active-high values; polarity is applied on the way out.
   assign seg        = seg_q ^ {7{INV}};
   assign dp         = dp_q ^ INV;
   assign an         = an_q ^ {NUM_DIGITS{INV}};
   assign evt_led    = (evt_cnt_q != '0);
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner against a cycle-count based reference model.
module tb_bcd_display_scanner;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int EF = 2;

   logic        clk = 1'b0;
   logic        a_clr = 1'b0;
   logic [15:0] digits = '0;
   logic [3:0]  dp_mask = '0;
   logic        hold = 1'b0;
   logic        lzb_en = 1'b0;
   logic        evt_pulse = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        evt_led;
   logic        frame_tick;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: position in the scan is derived purely from edges since reset.
   int          k;
   logic [15:0] snap_m;
   logic [3:0]  dpm_m;
   int          evt_m;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_ft;
   logic [6:0]  seg_tab [16];

   bcd_display_scanner #(
      .NUM_DIGITS   (N),
      .SCAN_DIV     (SD),
      .EVT_FRAMES   (EF),
      .COMMON_ANODE (0)
   ) dut (
      .clk        (clk),
      .a_clr      (a_clr),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .hold       (hold),
      .lzb_en     (lzb_en),
      .evt_pulse  (evt_pulse),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .evt_led    (evt_led),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      k      = 0;
      snap_m = '0;
      dpm_m  = '0;
      evt_m  = 0;
      e_seg  = '0;
      e_dp   = 1'b0;
      e_an   = '0;
      e_ft   = 1'b0;
   endtask

   task automatic check_all();
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("an", 32'(an), 32'(e_an));
      check("evt_led", 32'(evt_led), 32'(evt_m != 0));
      check("frame_tick", 32'(frame_tick), 32'(e_ft));
   endtask

   // Apply inputs for one clock, advance the model across that edge, check at negedge.
   task automatic cycle(input logic [15:0] d, input logic [3:0] m, input logic h,
                        input logic lz, input logic p);
      int         idx_old;
      logic [3:0] nib;
      logic       blank;
      digits    = d;
      dp_mask   = m;
      hold      = h;
      lzb_en    = lz;
      evt_pulse = p;
      idx_old = (k / SD) % N;
      nib     = 4'(snap_m >> (4 * idx_old));
      blank   = lz && (idx_old != 0) && ((snap_m >> (4 * idx_old)) == 16'd0);
      e_seg   = blank ? 7'h00 : seg_tab[nib];
      e_dp    = dpm_m[idx_old];
      e_an    = 4'(1 << idx_old);
      if (p) evt_m = EF;
      else if (e_ft && evt_m > 0) evt_m--;
      k++;
      e_ft = ((k % (SD * N)) == 0);
      if (!h) begin
         snap_m = d;
         dpm_m  = m;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      logic [3:0]  nib;
      v = '0;
      for (int i = 0; i < N; i++) begin
         nib = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) nib = 4'd0;
         v[4*i +: 4] = nib;
      end
      return v;
   endfunction

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      #2 a_clr = 1'b1;

      // Directed patterns: plain decode, blanking, all-zero, invalid code.
      for (int i = 0; i < 20; i++) cycle(16'h1234, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(16'h0045, 4'h5, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cycle(16'h0000, 4'hA, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cycle(16'h000C, 4'h0, 1'b0, 1'b0, 1'b0);

      // Hold freezes the snapshot while scanning continues.
      for (int i = 0; i < 2; i++)  cycle(16'h0007, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) cycle(16'h0009, 4'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b0);

      // Single event pulse, then one coincident with frame_tick.
      cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 50; i++) cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && !e_ft; i++) cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b0);
      cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 50; i++) cycle(16'h0009, 4'h0, 1'b0, 1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(rand_digits(), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      end

      // Asynchronous reset in mid-slot with the event LED lit.
      cycle(16'h5678, 4'hF, 1'b0, 1'b0, 1'b1);
      cycle(16'h5678, 4'hF, 1'b0, 1'b0, 1'b0);
      cycle(16'h5678, 4'hF, 1'b0, 1'b0, 1'b0);
      #2 a_clr = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      #2 a_clr = 1'b1;
      for (int i = 0; i < 40; i++) cycle(16'h5678, 4'h3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         cycle(rand_digits(), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
